mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the core's instruction-fetch and data ports.
//  Sits between core_riscv (imem_*/dmem_* side) and a single-port BRAM.
//  Data requests have priority; a streak limit stops fetch starvation.
//  One read is outstanding at a time; reads return after a fixed memory latency.
// PARAMETERS
//  RD_LATENCY    1  cycles from the issue edge to valid mem_rdata_i (>=1)
//  MAX_D_STREAK  4  max consecutive D grants while I is waiting (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_i        in   1   asynchronous, active-high reset
//  i_req_i      in   1   fetch request; held with i_addr_i until i_gnt_o
//  i_addr_i     in   32  fetch byte address
//  i_gnt_o      out  1   fetch issued to memory this cycle
//  i_rvalid_o   out  1   i_rdata_o valid
//  i_rdata_o    out  32  fetch data (= mem_rdata_i)
//  d_req_i      in   1   data request; held with all d_* inputs until d_gnt_o
//  d_we_i       in   1   1 = store, 0 = load
//  d_addr_i     in   32  data byte address
//  d_wdata_i    in   32  store data
//  d_size_i     in   2   00 byte, 01 half, 10 word
//  d_sign_i     in   1   load sign-extend (passed through)
//  d_gnt_o      out  1   data access issued this cycle
//  d_rvalid_o   out  1   d_rdata_o valid (loads only)
//  d_rdata_o    out  32  load data (= mem_rdata_i)
//  mem_addr_o   out  32  memory address
//  mem_wdata_o  out  32  memory write data
//  mem_we_o     out  1   memory write strobe
//  mem_re_o     out  1   memory read strobe
//  mem_size_o   out  2   access size
//  mem_sign_o   out  1   access sign
//  mem_rdata_i  in   32  memory read data
// BEHAVIOUR
//  Reset
//   - All gnt/rvalid/we/re outputs are 0. FSM goes to IDLE, streak = 0.
//   - An in-flight read is dropped; no rvalid is asserted for it.
//  FSM
//   - IDLE: issue is allowed.
//   - WAIT: a read is outstanding. A down-counter is loaded with RD_LATENCY-1 at the issue edge
//     (counter width $clog2(RD_LATENCY+1)).
//   - Leave WAIT in the cycle the counter is 0. In that cycle, assert the owner's rvalid.
//     The issue logic also runs that cycle as if in IDLE, so back-to-back reads are allowed.
//  Issue
//   - Issue is combinational in the granting cycle: gnt=1 and mem_* are driven from the winner's
//     inputs. The owner (I/D) is registered.
//   - Read issue: mem_re_o=1, then next state is WAIT.
//   - Write issue: mem_we_o=1, no rvalid. Next state is IDLE unless a read is being returned.
//   - When nothing is issued: mem_we_o/mem_re_o = 0 and mem_addr_o/wdata/size/sign = 0.
//   - Fetch is always size 10 (word), sign 0.
//  Priority
//   - D wins unless (i_req_i && streak == MAX_D_STREAK), in which case I wins.
//   - streak increments on a D grant while i_req_i=1 and saturates at MAX_D_STREAK.
//   - streak clears on an I grant or whenever i_req_i=0.
//  Rules
//   - At most one gnt per cycle. rvalid is a single-cycle pulse.
//   - A requester must not drop req before gnt. Behaviour if it does is undefined.
//   - rdata outputs are combinational pass-throughs; they are meaningful only with rvalid.
// STRUCTURE
//  - mem_arb_pkg holds:
//    - typedef enum {IDLE, WAIT} arb_state_t
//    - typedef enum {OWN_I, OWN_D} arb_owner_t
//    - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams
//  - One sub-module, mem_arb_prio: the streak counter plus the winner select.
//  - FSM, latency counter and mux stay in the top level.
// TESTING
//  1. Reset, then i_req_i=1, addr 0x100, RD_LATENCY=1:
//     i_gnt_o same cycle with mem_re_o=1, addr 0x100; i_rvalid_o next cycle with data.
//  2. i_req_i and d_req_i (load 0x200) both held high:
//     D granted 4 times in a row, then I on the 5th arbitration; the pattern repeats.
//  3. Store: d_we_i=1, addr 0x40, wdata 0xDEADBEEF, size 10:
//     d_gnt_o=1 and mem_we_o=1 for exactly one cycle, no d_rvalid_o; readback returns 0xDEADBEEF.
//  4. RD_LATENCY=3, back-to-back I reads:
//     gnt at cycles 0 and 3, rvalid at cycles 3 and 6. No issue is allowed in cycles 1-2.
//  5. Assert rst_i in WAIT one cycle after a D load grant:
//     no d_rvalid_o; all outputs 0 while reset is high; the next request is issued normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and size encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter view, master = core+BRAM view.
interface mem_arbiter_if;

  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_size_i;
  logic        d_sign_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [1:0]  mem_size_o;
  logic        mem_sign_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_size_i, d_sign_i,
    input  mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mem_size_o, mem_sign_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_size_i, d_sign_i,
    output mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mem_size_o, mem_sign_o
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data, with a data-grant streak limit so fetch is not starved.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic issue_en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_win_o,
  output logic d_win_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          streak_full;

  assign streak_full = (streak_q == SW'(MAX_D_STREAK));
  assign d_win_o     = issue_en_i && d_req_i && !(i_req_i && streak_full);
  assign i_win_o     = issue_en_i && i_req_i && !d_win_o;

  // streak only counts data grants taken while fetch was kept waiting
  always_comb begin
    streak_d = streak_q;
    if (!i_req_i || i_win_o) begin
      streak_d = '0;
    end else if (d_win_o && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and data ports; one read outstanding
// at a time, returned after a fixed latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int             CW       = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(RD_LATENCY - 1);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_now, issue_en, i_win, d_win;

  // the return cycle doubles as an issue slot so reads can go back-to-back
  assign ret_now  = (state_q == WAIT) && (cnt_q == '0);
  assign issue_en = !rst_i && ((state_q == IDLE) || ret_now);

  mem_arb_prio #(.MAX_D_STREAK(MAX_D_STREAK)) u_prio (
    .clk        (clk),
    .rst_i      (rst_i),
    .issue_en_i (issue_en),
    .i_req_i    (bus.i_req_i),
    .d_req_i    (bus.d_req_i),
    .i_win_o    (i_win),
    .d_win_o    (d_win)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    cnt_d            = cnt_q;
    bus.i_gnt_o      = 1'b0;
    bus.d_gnt_o      = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.mem_we_o     = 1'b0;
    bus.mem_re_o     = 1'b0;
    bus.mem_size_o   = '0;
    bus.mem_sign_o   = 1'b0;

    if (state_q == WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = IDLE;
      end
    end

    if (d_win) begin
      bus.d_gnt_o     = 1'b1;
      bus.mem_addr_o  = bus.d_addr_i;
      bus.mem_wdata_o = bus.d_wdata_i;
      bus.mem_size_o  = bus.d_size_i;
      bus.mem_sign_o  = bus.d_sign_i;
      bus.mem_we_o    = bus.d_we_i;
      bus.mem_re_o    = !bus.d_we_i;
      if (!bus.d_we_i) begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
        owner_d = OWN_D;
      end
    end else if (i_win) begin
      bus.i_gnt_o    = 1'b1;
      bus.mem_addr_o = bus.i_addr_i;
      bus.mem_size_o = SIZE_WORD;
      bus.mem_re_o   = 1'b1;
      state_d        = WAIT;
      cnt_d          = CNT_LOAD;
      owner_d        = OWN_I;
    end
  end

  assign bus.i_rvalid_o = ret_now && (owner_q == OWN_I);
  assign bus.d_rvalid_o = ret_now && (owner_q == OWN_D);
  assign bus.i_rdata_o  = bus.mem_rdata_i;
  assign bus.d_rdata_o  = bus.mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random fetch/data traffic against two arbiters (read latency 1 and 3), checked cycle by cycle
// against a due-time reference model and a BRAM model per instance.
module tb_mem_arbiter;

  localparam int NCYC    = 3000;
  localparam int MAXS    = 4;
  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  logic        i_req[2], d_req[2], d_we[2], d_sign[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2];
  logic [1:0]  d_size[2];

  logic        o_igr[2], o_dgr[2], o_irv[2], o_drv[2], o_we[2], o_re[2], o_sign[2];
  logic [31:0] o_irdata[2], o_drdata[2], o_addr[2], o_wdata[2], mem_rdata[2];
  logic [1:0]  o_size[2];

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.RD_LATENCY(1), .MAX_D_STREAK(MAXS)) dut_l1 (.clk(clk), .rst_i(rst), .bus(bus0));
  mem_arbiter #(.RD_LATENCY(3), .MAX_D_STREAK(MAXS)) dut_l3 (.clk(clk), .rst_i(rst), .bus(bus1));

  assign bus0.i_req_i = i_req[0];    assign bus1.i_req_i = i_req[1];
  assign bus0.i_addr_i = i_addr[0];  assign bus1.i_addr_i = i_addr[1];
  assign bus0.d_req_i = d_req[0];    assign bus1.d_req_i = d_req[1];
  assign bus0.d_we_i = d_we[0];      assign bus1.d_we_i = d_we[1];
  assign bus0.d_addr_i = d_addr[0];  assign bus1.d_addr_i = d_addr[1];
  assign bus0.d_wdata_i = d_wdata[0]; assign bus1.d_wdata_i = d_wdata[1];
  assign bus0.d_size_i = d_size[0];  assign bus1.d_size_i = d_size[1];
  assign bus0.d_sign_i = d_sign[0];  assign bus1.d_sign_i = d_sign[1];
  assign bus0.mem_rdata_i = mem_rdata[0]; assign bus1.mem_rdata_i = mem_rdata[1];

  assign o_igr[0] = bus0.i_gnt_o;      assign o_igr[1] = bus1.i_gnt_o;
  assign o_dgr[0] = bus0.d_gnt_o;      assign o_dgr[1] = bus1.d_gnt_o;
  assign o_irv[0] = bus0.i_rvalid_o;   assign o_irv[1] = bus1.i_rvalid_o;
  assign o_drv[0] = bus0.d_rvalid_o;   assign o_drv[1] = bus1.d_rvalid_o;
  assign o_irdata[0] = bus0.i_rdata_o; assign o_irdata[1] = bus1.i_rdata_o;
  assign o_drdata[0] = bus0.d_rdata_o; assign o_drdata[1] = bus1.d_rdata_o;
  assign o_addr[0] = bus0.mem_addr_o;  assign o_addr[1] = bus1.mem_addr_o;
  assign o_wdata[0] = bus0.mem_wdata_o; assign o_wdata[1] = bus1.mem_wdata_o;
  assign o_we[0] = bus0.mem_we_o;      assign o_we[1] = bus1.mem_we_o;
  assign o_re[0] = bus0.mem_re_o;      assign o_re[1] = bus1.mem_re_o;
  assign o_size[0] = bus0.mem_size_o;  assign o_size[1] = bus1.mem_size_o;
  assign o_sign[0] = bus0.mem_sign_o;  assign o_sign[1] = bus1.mem_sign_o;

  // BRAM model: read data appears LAT cycles after the issue edge
  logic [31:0] tbmem[2][64];
  logic [31:0] pipe[2][3];

  function automatic logic [31:0] mem_pat(input int k, input int j);
    return 32'hA500_0000 ^ (32'(j) * 32'h0101_0101) ^ 32'(k);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int j = 0; j < 64; j++) tbmem[k][j] <= mem_pat(k, j);
      end else begin
        if (o_we[k]) tbmem[k][o_addr[k][7:2]] <= o_wdata[k];
        if (o_re[k]) pipe[k][0] <= tbmem[k][o_addr[k][7:2]];
        pipe[k][1] <= pipe[k][0];
        pipe[k][2] <= pipe[k][1];
      end
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // reference model state: one outstanding read with an absolute due cycle
  logic [31:0] m_mem[2][64];
  bit          ov[2];
  int          due[2];
  bit          own_d[2];
  logic [31:0] odata[2];
  int          streak[2];
  bit          m_igr[2], m_dgr[2], last_dload[2];
  int          cyc;

  task automatic model_step(input int k);
    bit          ret, free, dwin, iwin;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    string       p;
    p = $sformatf("L%0d", LAT[k]);
    if (rst) begin
      chk({p, "_rst_igr"}, 32'(o_igr[k]), 32'd0);
      chk({p, "_rst_dgr"}, 32'(o_dgr[k]), 32'd0);
      chk({p, "_rst_irv"}, 32'(o_irv[k]), 32'd0);
      chk({p, "_rst_drv"}, 32'(o_drv[k]), 32'd0);
      chk({p, "_rst_we"},  32'(o_we[k]),  32'd0);
      chk({p, "_rst_re"},  32'(o_re[k]),  32'd0);
      chk({p, "_rst_addr"}, o_addr[k],    32'd0);
      ov[k] = 0; streak[k] = 0;
      m_igr[k] = 0; m_dgr[k] = 0; last_dload[k] = 0;
      return;
    end
    ret  = ov[k] && (due[k] == cyc);
    free = !ov[k] || ret;
    chk({p, "_irv"}, 32'(o_irv[k]), 32'(ret && !own_d[k]));
    chk({p, "_drv"}, 32'(o_drv[k]), 32'(ret && own_d[k]));
    if (ret && !own_d[k]) chk({p, "_irdata"}, o_irdata[k], odata[k]);
    if (ret && own_d[k])  chk({p, "_drdata"}, o_drdata[k], odata[k]);

    dwin = free && d_req[k] && !(i_req[k] && streak[k] == MAXS);
    iwin = free && i_req[k] && !dwin;
    e_addr  = dwin ? d_addr[k] : (iwin ? i_addr[k] : 32'd0);
    e_wdata = dwin ? d_wdata[k] : 32'd0;
    e_size  = dwin ? d_size[k] : (iwin ? 2'b10 : 2'b00);
    chk({p, "_igr"},   32'(o_igr[k]),  32'(iwin));
    chk({p, "_dgr"},   32'(o_dgr[k]),  32'(dwin));
    chk({p, "_we"},    32'(o_we[k]),   32'(dwin && d_we[k]));
    chk({p, "_re"},    32'(o_re[k]),   32'((dwin && !d_we[k]) || iwin));
    chk({p, "_addr"},  o_addr[k],      e_addr);
    chk({p, "_wdata"}, o_wdata[k],     e_wdata);
    chk({p, "_size"},  32'(o_size[k]), 32'(e_size));
    chk({p, "_sign"},  32'(o_sign[k]), 32'(dwin && d_sign[k]));

    if (ret) ov[k] = 0;
    if (dwin && d_we[k]) m_mem[k][d_addr[k][7:2]] = d_wdata[k];
    if ((dwin && !d_we[k]) || iwin) begin
      ov[k]    = 1;
      due[k]   = cyc + LAT[k];
      own_d[k] = dwin;
      odata[k] = m_mem[k][e_addr[7:2]];
    end
    if (!i_req[k] || iwin) streak[k] = 0;
    else if (dwin && streak[k] < MAXS) streak[k] = streak[k] + 1;
    m_igr[k] = iwin;
    m_dgr[k] = dwin;
    last_dload[k] = dwin && !d_we[k];
  endtask

  task automatic drive_reqs(input int k);
    if (i_req[k] && m_igr[k]) i_req[k] = 1'b0;
    if (!i_req[k] && $urandom_range(0, 99) < 60) begin
      i_req[k]  = 1'b1;
      i_addr[k] = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    end
    if (d_req[k] && m_dgr[k]) d_req[k] = 1'b0;
    if (!d_req[k] && $urandom_range(0, 99) < 70) begin
      d_req[k]   = 1'b1;
      d_we[k]    = ($urandom_range(0, 2) == 0);
      d_addr[k]  = {24'd0, 6'($urandom_range(0, 15)), 2'b00};
      d_wdata[k] = $urandom;
      d_size[k]  = 2'($urandom_range(0, 2));
      d_sign[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  int rst_cnt;
  int n_resets;

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 0; i_addr[k] = 0;
      d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; d_size[k] = 0; d_sign[k] = 0;
      for (int j = 0; j < 64; j++) m_mem[k][j] = mem_pat(k, j);
      ov[k] = 0; due[k] = 0; own_d[k] = 0; odata[k] = 0; streak[k] = 0;
      m_igr[k] = 0; m_dgr[k] = 0; last_dload[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    rst_cnt  = 2;
    n_resets = 0;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst = 1'b1;
        rst_cnt--;
      end else if (n_resets < 4 && cyc > 400 * (n_resets + 1) && last_dload[1]) begin
        // hits the latency-3 instance one cycle into its WAIT
        rst = 1'b1;
        rst_cnt = 1;
        n_resets++;
      end else begin
        rst = 1'b0;
      end
      drive_reqs(0);
      drive_reqs(1);
      @(negedge clk);
      model_step(0);
      model_step(1);
    end
    chk("reset_events", 32'(n_resets > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
